// File: rtl/msched_driver_if.sv
// rtl/msched_driver_if.sv - opcode package and handshake/ALU bus interface for msched_driver
//
// msched_pkg     : instruction_s opcode type shared with the alu.
// msched_driver_if signals:
//   in_valid_i / in_data_i / in_ready_o    block-word load handshake (W0 first)
//   out_valid_o / out_data_o / out_ready_i schedule-word output handshake (W0..W63)
//   done_o                                 one-cycle pulse after W63 transfers
//   busy_o                                 high outside LOAD
//   alu_op_o / alu_rd_o / alu_rs_o         operands to the shared alu
//   alu_result_i                           combinational alu result
// Modports: slave = msched_driver side, master = parent / environment side.

package msched_pkg;
    typedef enum logic [1:0] {
        kMOV  = 2'd0,
        kADDU = 2'd1,
        kLA   = 2'd2,
        kLB   = 2'd3
    } instruction_s;
endpackage

interface msched_driver_if;
    import msched_pkg::*;

    logic         in_valid_i;
    logic [31:0]  in_data_i;
    logic         in_ready_o;
    logic         out_valid_o;
    logic [31:0]  out_data_o;
    logic         out_ready_i;
    logic         done_o;
    logic         busy_o;
    instruction_s alu_op_o;
    logic [31:0]  alu_rd_o;
    logic [31:0]  alu_rs_o;
    logic [31:0]  alu_result_i;

    modport slave (
        input  in_valid_i, in_data_i, out_ready_i, alu_result_i,
        output in_ready_o, out_valid_o, out_data_o, done_o, busy_o,
               alu_op_o, alu_rd_o, alu_rs_o
    );

    modport master (
        output in_valid_i, in_data_i, out_ready_i, alu_result_i,
        input  in_ready_o, out_valid_o, out_data_o, done_o, busy_o,
               alu_op_o, alu_rd_o, alu_rs_o
    );
endinterface

// File: rtl/msched_driver.sv
// rtl/msched_driver.sv - SHA-256 message-schedule sequencer driving a shared alu
//
// Ports:
//   clk      rising-edge clock
//   n_reset  asynchronous active-low reset
//   bus      msched_driver_if.slave: load handshake, schedule output
//            handshake, done/busy status and the alu operand/result bus
//
// Loads 16 words into a circular buffer, streams W0..W15, then computes
// W16..W63 in five alu steps each (sigma0, sigma1, three adds) and streams
// every computed word as soon as it is produced.

module msched_driver
    import msched_pkg::*;
(
    input  logic           clk,
    input  logic           n_reset,
    msched_driver_if.slave bus
);

    localparam logic [2:0] S_LOAD  = 3'd0;
    localparam logic [2:0] S_EMIT  = 3'd1;
    localparam logic [2:0] S_CALC0 = 3'd2;
    localparam logic [2:0] S_CALC1 = 3'd3;
    localparam logic [2:0] S_CALC2 = 3'd4;
    localparam logic [2:0] S_CALC3 = 3'd5;
    localparam logic [2:0] S_CALC4 = 3'd6;
    localparam logic [2:0] S_OUT   = 3'd7;

    logic [2:0]  r_state;
    logic [31:0] r_buf [16];
    logic [3:0]  r_cnt;
    logic [5:0]  r_t;
    logic [31:0] r_tmp;
    logic [31:0] r_acc;
    logic [31:0] r_out;
    logic        r_done;

    logic [3:0]  w_slot;
    logic [3:0]  w_slot_m15;
    logic [3:0]  w_slot_m2;
    logic [3:0]  w_slot_m7;
    logic        w_in_fire;
    logic        w_out_fire;

    // Slot t holds W[t-16] until CALC4 overwrites it; the other taps are
    // W[t-15], W[t-2] and W[t-7], i.e. slot offsets +1, +14 and +9 mod 16.
    assign w_slot     = r_t[3:0];
    assign w_slot_m15 = w_slot + 4'd1;
    assign w_slot_m2  = w_slot + 4'd14;
    assign w_slot_m7  = w_slot + 4'd9;

    assign bus.in_ready_o  = (r_state == S_LOAD);
    assign bus.busy_o      = (r_state != S_LOAD);
    assign bus.out_valid_o = (r_state == S_EMIT) || (r_state == S_OUT);
    assign bus.out_data_o  = (r_state == S_EMIT) ? r_buf[w_slot] : r_out;
    assign bus.done_o      = r_done;

    assign w_in_fire  = bus.in_valid_i && bus.in_ready_o;
    assign w_out_fire = bus.out_valid_o && bus.out_ready_i;

    always_comb begin
        bus.alu_op_o = kMOV;
        bus.alu_rd_o = 32'd0;
        bus.alu_rs_o = 32'd0;
        case (r_state)
            S_CALC0: begin
                bus.alu_op_o = kLA;
                bus.alu_rs_o = r_buf[w_slot_m15];
            end
            S_CALC1: begin
                bus.alu_op_o = kLB;
                bus.alu_rs_o = r_buf[w_slot_m2];
            end
            S_CALC2: begin
                bus.alu_op_o = kADDU;
                bus.alu_rd_o = r_acc;
                bus.alu_rs_o = r_tmp;
            end
            S_CALC3: begin
                bus.alu_op_o = kADDU;
                bus.alu_rd_o = r_acc;
                bus.alu_rs_o = r_buf[w_slot_m7];
            end
            S_CALC4: begin
                bus.alu_op_o = kADDU;
                bus.alu_rd_o = r_acc;
                bus.alu_rs_o = r_buf[w_slot];
            end
            default: begin
                bus.alu_op_o = kMOV;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state <= S_LOAD;
            r_cnt   <= 4'd0;
            r_t     <= 6'd0;
            r_tmp   <= 32'd0;
            r_acc   <= 32'd0;
            r_out   <= 32'd0;
            r_done  <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                r_buf[i] <= 32'd0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_LOAD: begin
                    if (w_in_fire) begin
                        r_buf[r_cnt] <= bus.in_data_i;
                        r_cnt        <= r_cnt + 4'd1;
                        if (r_cnt == 4'd15) begin
                            r_state <= S_EMIT;
                            r_t     <= 6'd0;
                        end
                    end
                end
                S_EMIT: begin
                    if (w_out_fire) begin
                        // t rolls from 15 to 16 on the last raw word.
                        r_t <= r_t + 6'd1;
                        if (r_t == 6'd15) begin
                            r_state <= S_CALC0;
                        end
                    end
                end
                S_CALC0: begin
                    r_tmp   <= bus.alu_result_i;
                    r_state <= S_CALC1;
                end
                S_CALC1: begin
                    r_acc   <= bus.alu_result_i;
                    r_state <= S_CALC2;
                end
                S_CALC2: begin
                    r_acc   <= bus.alu_result_i;
                    r_state <= S_CALC3;
                end
                S_CALC3: begin
                    r_acc   <= bus.alu_result_i;
                    r_state <= S_CALC4;
                end
                S_CALC4: begin
                    r_buf[w_slot] <= bus.alu_result_i;
                    r_out         <= bus.alu_result_i;
                    r_state       <= S_OUT;
                end
                S_OUT: begin
                    if (w_out_fire) begin
                        if (r_t == 6'd63) begin
                            r_state <= S_LOAD;
                            r_t     <= 6'd0;
                            r_done  <= 1'b1;
                        end else begin
                            r_t     <= r_t + 6'd1;
                            r_state <= S_CALC0;
                        end
                    end
                end
                default: begin
                    r_state <= S_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_msched_driver.sv
// tb/tb_msched_driver.sv - self-checking bench for msched_driver

module tb_msched_driver;
    import msched_pkg::*;

    logic clk = 1'b0;
    logic n_reset;
    always #5 clk = ~clk;

    msched_driver_if bus();

    msched_driver dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] cur_blk [16];
    logic [31:0] exp_w   [64];
    logic [31:0] got     [$];
    int          done_cnt  = 0;
    int          stall_bad = 0;
    bit          throttle  = 1'b0;
    logic        prev_stall;
    logic [31:0] prev_data;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Behavioural alu attached to the driver's alu port.
    always_comb begin
        case (bus.alu_op_o)
            kLA:     bus.alu_result_i = sig0(bus.alu_rs_o);
            kLB:     bus.alu_result_i = sig1(bus.alu_rs_o);
            kADDU:   bus.alu_result_i = bus.alu_rd_o + bus.alu_rs_o;
            default: bus.alu_result_i = bus.alu_rs_o;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference SHA-256 message schedule.
    task automatic build_model();
        for (int i = 0; i < 16; i++) exp_w[i] = cur_blk[i];
        for (int i = 16; i < 64; i++)
            exp_w[i] = sig1(exp_w[i-2]) + exp_w[i-7] + sig0(exp_w[i-15]) + exp_w[i-16];
    endtask

    // Output monitor: records transfers, counts done pulses, checks stall stability.
    initial begin
        prev_stall = 1'b0;
        prev_data  = 32'd0;
        forever begin
            @(negedge clk);
            if (!n_reset) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall && !(bus.out_valid_o && bus.out_data_o == prev_data))
                    stall_bad++;
                if (bus.out_valid_o && bus.out_ready_i) got.push_back(bus.out_data_o);
                if (bus.done_o) done_cnt++;
                prev_stall = bus.out_valid_o && !bus.out_ready_i;
                prev_data  = bus.out_data_o;
            end
        end
    end

    // Downstream ready: always high, or ~30% high when throttled.
    initial begin
        bus.out_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready_i = throttle ? ($urandom_range(0, 9) < 3) : 1'b1;
        end
    end

    task automatic load_block();
        for (int i = 0; i < 16; i++) begin
            bus.in_valid_i = 1'b1;
            bus.in_data_i  = cur_blk[i];
            check($sformatf("in_ready_w%0d", i), {31'd0, bus.in_ready_o}, 32'd1);
            @(posedge clk);
            #1;
        end
        bus.in_valid_i = 1'b0;
        bus.in_data_i  = 32'd0;
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        int busy_bad = 0;
        for (int c = 0; c < 6000; c++) begin
            @(negedge clk);
            #1;
            if (bus.done_o) begin
                ok = 1'b1;
                break;
            end
            if (!bus.busy_o) busy_bad++;
        end
        check("done_within_budget", {31'd0, ok}, 32'd1);
        check("busy_low_cycles_in_block", 32'(busy_bad), 32'd0);
        if (ok) begin
            check("busy_at_done", {31'd0, bus.busy_o}, 32'd0);
            check("in_ready_at_done", {31'd0, bus.in_ready_o}, 32'd1);
        end
    endtask

    task automatic check_stream();
        build_model();
        check("stream_len", 32'(got.size()), 32'd64);
        for (int i = 0; i < 64 && i < got.size(); i++)
            check($sformatf("W%0d", i), got[i], exp_w[i]);
        got.delete();
    endtask

    task automatic set_abc();
        for (int i = 0; i < 16; i++) cur_blk[i] = 32'd0;
        cur_blk[0]  = 32'h61626380;
        cur_blk[15] = 32'h00000018;
    endtask

    typedef struct {
        logic [31:0] w0;
        logic [31:0] w15;
        logic [31:0] e16;
        logic [31:0] e17;
        bit          thr;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int          d0;
        bit          found;
        logic [31:0] r16;
        logic [31:0] r17;

        vecs[0] = '{w0: 32'h61626380, w15: 32'h00000018, e16: 32'h61626380, e17: 32'h000F0000, thr: 1'b0};
        vecs[1] = '{w0: 32'h00000000, w15: 32'h00000000, e16: 32'h00000000, e17: 32'h00000000, thr: 1'b0};
        vecs[2] = '{w0: 32'h00000000, w15: 32'h00000400, e16: 32'h00000000, e17: 32'h02800001, thr: 1'b1};
        vecs[3] = '{w0: 32'hFFFFFFFF, w15: 32'h00000018, e16: 32'hFFFFFFFF, e17: 32'h000F0000, thr: 1'b1};

        bus.in_valid_i = 1'b0;
        bus.in_data_i  = 32'd0;
        n_reset        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  {31'd0, bus.in_ready_o},  32'd1);
        check("rst_out_valid", {31'd0, bus.out_valid_o}, 32'd0);
        check("rst_done",      {31'd0, bus.done_o},      32'd0);
        check("rst_busy",      {31'd0, bus.busy_o},      32'd0);
        check("rst_alu_op",    {30'd0, bus.alu_op_o},    {30'd0, kMOV});
        check("rst_alu_rd",    bus.alu_rd_o,             32'd0);
        check("rst_alu_rs",    bus.alu_rs_o,             32'd0);
        n_reset = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven blocks.
        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < 16; i++) cur_blk[i] = 32'd0;
            cur_blk[0]  = vecs[v].w0;
            cur_blk[15] = vecs[v].w15;
            throttle    = vecs[v].thr;
            d0          = done_cnt;
            stall_bad   = 0;
            load_block();
            wait_done();
            r16 = (got.size() > 16) ? got[16] : 32'hDEADBEEF;
            r17 = (got.size() > 17) ? got[17] : 32'hDEADBEEF;
            check($sformatf("vec%0d_W16", v), r16, vecs[v].e16);
            check($sformatf("vec%0d_W17", v), r17, vecs[v].e17);
            check_stream();
            check($sformatf("vec%0d_done_pulses", v), 32'(done_cnt - d0), 32'd1);
            check($sformatf("vec%0d_stall_stable", v), 32'(stall_bad), 32'd0);
        end

        // Random blocks under backpressure.
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 16; i++) cur_blk[i] = $urandom;
            throttle  = 1'b1;
            d0        = done_cnt;
            stall_bad = 0;
            load_block();
            wait_done();
            check_stream();
            check("rand_done_pulses", 32'(done_cnt - d0), 32'd1);
            check("rand_stall_stable", 32'(stall_bad), 32'd0);
        end

        // ALU trace at t = 16 for the abc block.
        throttle = 1'b0;
        set_abc();
        load_block();
        found = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            #1;
            if (bus.alu_op_o == kLA) begin
                found = 1'b1;
                break;
            end
        end
        check("trace_found_calc0", {31'd0, found}, 32'd1);
        check("trace_calc0_op", {30'd0, bus.alu_op_o}, {30'd0, kLA});
        check("trace_calc0_rs", bus.alu_rs_o, 32'd0);
        @(negedge clk); #1;
        check("trace_calc1_op", {30'd0, bus.alu_op_o}, {30'd0, kLB});
        @(negedge clk); #1;
        check("trace_calc2_op", {30'd0, bus.alu_op_o}, {30'd0, kADDU});
        @(negedge clk); #1;
        check("trace_calc3_op", {30'd0, bus.alu_op_o}, {30'd0, kADDU});
        @(negedge clk); #1;
        check("trace_calc4_op", {30'd0, bus.alu_op_o}, {30'd0, kADDU});
        check("trace_calc4_rs", bus.alu_rs_o, 32'h61626380);
        check("trace_calc4_valid", {31'd0, bus.out_valid_o}, 32'd0);
        @(negedge clk); #1;
        check("trace_out_valid", {31'd0, bus.out_valid_o}, 32'd1);
        check("trace_out_data", bus.out_data_o, 32'h61626380);
        wait_done();
        check_stream();

        // Reset during CALC2 of t = 40.
        set_abc();
        load_block();
        found = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            #1;
            if (got.size() == 40 && bus.alu_op_o == kADDU) begin
                found = 1'b1;
                break;
            end
        end
        check("midrst_reached_calc2", {31'd0, found}, 32'd1);
        n_reset = 1'b0;
        #1;
        check("midrst_in_ready",  {31'd0, bus.in_ready_o},  32'd1);
        check("midrst_out_valid", {31'd0, bus.out_valid_o}, 32'd0);
        check("midrst_done",      {31'd0, bus.done_o},      32'd0);
        check("midrst_busy",      {31'd0, bus.busy_o},      32'd0);
        check("midrst_alu_op",    {30'd0, bus.alu_op_o},    {30'd0, kMOV});
        check("midrst_alu_rd",    bus.alu_rd_o,             32'd0);
        check("midrst_alu_rs",    bus.alu_rs_o,             32'd0);
        got.delete();
        d0 = done_cnt;
        repeat (2) @(posedge clk);
        #1;
        n_reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_no_partial_output", 32'(got.size()), 32'd0);
        check("midrst_idle_busy", {31'd0, bus.busy_o}, 32'd0);
        load_block();
        wait_done();
        check_stream();
        check("midrst_done_pulses", 32'(done_cnt - d0), 32'd1);

        // Back-to-back blocks: second block starts in the done cycle.
        d0 = done_cnt;
        for (int i = 0; i < 16; i++) cur_blk[i] = $urandom;
        load_block();
        wait_done();
        check_stream();
        for (int i = 0; i < 16; i++) cur_blk[i] = $urandom;
        load_block();
        wait_done();
        check_stream();
        repeat (3) @(posedge clk);
        #1;
        check("b2b_done_pulses", 32'(done_cnt - d0), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/msched_driver.md
# msched_driver

SHA-256 message-schedule sequencer for the miner core. Accepts the 16 words of a block, drives the `alu` operand/opcode interface to compute W16..W63 with the sigma ops (`kLA` = σ0, `kLB` = σ1) and `kADDU`, and streams W0..W63 out in order. It sits between the block loader and the compression datapath, and time-shares one `alu` instance that the parent connects to its `alu_*` ports.

## Interface
- No parameters. Word width fixed at 32; block = 16 words; schedule = 64 words.
- `clk`  in  1  clock; all state updates on the rising edge.
- `n_reset`  in  1  asynchronous, active-low reset.
- `in_valid_i`  in  1  input word valid.
- `in_data_i`  in  32  input word; W0 first.
- `in_ready_o`  out  1  load handshake; a word transfers when `in_valid_i & in_ready_o`.
- `out_valid_o`  out  1  schedule word valid.
- `out_data_o`  out  32  W[t], emitted in order t = 0..63.
- `out_ready_i`  in  1  downstream accept; a word transfers when `out_valid_o & out_ready_i`.
- `done_o`  out  1  one-cycle pulse in the cycle after W63 transfers.
- `busy_o`  out  1  high in every state except LOAD.
- `alu_op_o`  out  `instruction_s`  opcode to the `alu` `op_i` port.
- `alu_rd_o`  out  32  to the `alu` `rd_i` port.
- `alu_rs_o`  out  32  to the `alu` `rs_i` port.
- `alu_result_i`  in  32  from the `alu` `result_o` port; combinational in the same cycle.

## Operation
- Storage: a 16×32 circular buffer `buf`. Word t lives in slot t[3:0]. The block also holds registers `tmp`, `acc` and `out_reg`, a load count `cnt` (4 bit) and a word index `t` (6 bit).
- State machine: LOAD → EMIT → CALC0..CALC4 → OUT → (CALC0 or LOAD).
- LOAD:
  - `in_ready_o` = 1.
  - Each transfer writes `buf[cnt]`, then increments `cnt`.
  - The transfer with `cnt` = 15 moves to EMIT with `t` = 0 and `cnt` wraps to 0.
- EMIT:
  - `out_valid_o` = 1 and `out_data_o` = `buf[t]`.
  - Each transfer increments `t`.
  - The transfer at `t` = 15 moves to CALC0 with `t` = 16.
- CALC steps take one cycle each and never stall. Slot indices are mod 16.
  - CALC0: op `kLA`, rs = `buf[t+1]` (W[t-15]), rd = 0. Latch `tmp` ← result.
  - CALC1: op `kLB`, rs = `buf[t+14]` (W[t-2]), rd = 0. Latch `acc` ← result.
  - CALC2: op `kADDU`, rd = `acc`, rs = `tmp`. Latch `acc` ← result.
  - CALC3: op `kADDU`, rd = `acc`, rs = `buf[t+9]` (W[t-7]). Latch `acc` ← result.
  - CALC4: op `kADDU`, rd = `acc`, rs = `buf[t]` (W[t-16], read before overwrite). Write `buf[t]` ← result and `out_reg` ← result, then go to OUT.
- OUT:
  - `out_valid_o` = 1 and `out_data_o` = `out_reg`. Hold both stable until the transfer.
  - On transfer with `t` = 63: go to LOAD and pulse `done_o` next cycle.
  - On any other transfer: increment `t` and go to CALC0.
- Outside CALC: `alu_op_o` = `kMOV`, `alu_rd_o` = 0, `alu_rs_o` = 0.
- `out_valid_o` = 0 in LOAD and in CALC.
- `in_ready_o` = 0 in every state except LOAD. Input is ignored outside LOAD.
- Arithmetic: all sums are modulo 2^32 with carry discarded, as produced by `kADDU`.

## Timing
- Reset values:
  - State LOAD; `cnt`, `t`, `tmp`, `acc`, `out_reg` and all `buf` slots are 0.
  - Outputs: `in_ready_o` = 1, `out_valid_o` = 0, `done_o` = 0, `busy_o` = 0.
  - `alu_op_o` = `kMOV`; `alu_rd_o` and `alu_rs_o` = 0.
- Asserting `n_reset` in any state, mid-CALC or mid-OUT included, aborts the block. No partial output follows; after release the block waits for a fresh W0.
- Load takes 16 transfer cycles minimum.
- W0..W15: one word per cycle while `out_ready_i` is high.
- Computed words:
  - `out_valid_o` for W[t] rises 5 cycles after the CALC0 edge.
  - Sustained rate is 6 cycles per word with `out_ready_i` held high.
  - Minimum block time is 16 + 16 + 48×6 = 320 cycles from the first load transfer to the W63 transfer.
- Backpressure: `out_ready_i` low in EMIT or OUT stalls indefinitely with the data held. No CALC progress occurs during a stall.
- `done_o` goes high in the cycle after the W63 transfer. `in_ready_o` is already 1 in that same cycle, so a new block may begin loading immediately.

## Test plan
- Stimulus: "abc" padded block, with W0 = 0x61626380, W1..W14 = 0, W15 = 0x00000018. Required response:
  - W16 = 0x61626380 and W17 = 0x000F0000.
  - All 64 words match the bench SHA-256 schedule model.
  - `done_o` pulses once.
- Stimulus: all-zero block. Required: all 64 outputs = 0 and `busy_o` high from the W15 load until the cycle before `done_o`.
- ALU trace check: for the abc block, at t = 16 `alu_op_o` follows `kLA`, `kLB`, `kADDU`, `kADDU`, `kADDU` on consecutive cycles. In CALC0 `alu_rs_o` = W1 = 0, and in CALC4 it is W0 = 0x61626380.
- Backpressure: random `out_ready_i` with about 30% high. Required: identical word sequence to the unthrottled run, `out_data_o` stable while stalled, no lost or duplicated words.
- Reset mid-operation:
  - Stimulus: assert `n_reset` during CALC2 of t = 40, release it, then load the abc block.
  - Required: outputs return to reset values immediately, then a correct full 64-word stream.
- Back-to-back blocks: assert the second block's `in_valid_i` in the `done_o` cycle. Required: the second block loads with no gap, produces a correct schedule, and `done_o` pulses exactly twice.
